// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the transmitter state encoding.
// Used by uart_tx and intended to supply DATA_BITS to uart_rx as well.
package uart_pkg;

   localparam int   DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

   // PARITY is always part of the encoding so both build flavours share one type;
   // it is only ever entered when UART_TX_PARITY_EN is defined.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// 8N1 / 8N2 UART transmitter with a one-entry holding buffer, driven by the shared
// one-clk-per-bit baud tick. Bytes are sent LSB first; a byte buffered during a
// frame follows the final stop bit with no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between the
// data and stop bits (PARITY_ODD selects odd parity).
module uart_tx
   import uart_pkg::*;
#(
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_start,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 tx
);

   localparam int                CNT_W     = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
   // Stop-bit counter is one bit wide: value of the counter during the final stop bit.
   localparam logic              STOP_LAST = (STOP_BITS == 2);

   // Reject configurations the stop counter and parity logic cannot represent.
   if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_tx: STOP_BITS must be 1 or 2 and PARITY_ODD must be 0 or 1");
   end

   tx_state_e             state_q, state_d;
   logic [DATA_BITS-1:0]  buf_q, buf_d;
   logic                  buf_empty_q, buf_empty_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   logic stop_last;
   assign stop_last = (stop_cnt_q == STOP_LAST);

   // State register: synchronous reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: the FSM advances only on clk edges that carry a baud tick.
   always_comb begin
      state_d = state_q;
      if (tick) begin
         unique case (state_q)
            IDLE:   if (!buf_empty_q) state_d = START;
            START:  state_d = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_cnt_q == LAST_BIT) state_d = PARITY;
            PARITY: state_d = STOP;
`else
            DATA:   if (bit_cnt_q == LAST_BIT) state_d = STOP;
`endif
            STOP:   if (stop_last) state_d = buf_empty_q ? IDLE : START;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output / datapath logic: buffer accept, shifter load and the next line value.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case
      // leaves one unassigned, which would otherwise infer a latch.
      buf_d       = buf_q;
      buf_empty_d = buf_empty_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      tx_d        = tx_q;
      done_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      // Accept only into an empty buffer; a drain needs a full buffer, so the two
      // can never collide on the same edge.
      if (tx_start && buf_empty_q) begin
         buf_d       = tx_data;
         buf_empty_d = 1'b0;
      end

      if (tick) begin
         unique case (state_q)
            IDLE: begin
               if (!buf_empty_q) begin
                  shift_d     = buf_q;
                  buf_empty_d = 1'b1;
                  tx_d        = START_BIT;
`ifdef UART_TX_PARITY_EN
                  parity_d    = ^buf_q;
`endif
               end else begin
                  tx_d = LINE_IDLE;
               end
            end
            START: begin
               tx_d      = shift_q[0];
               bit_cnt_d = '0;
            end
            DATA: begin
               if (bit_cnt_q == LAST_BIT) begin
                  stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                  tx_d = parity_q ^ 1'(PARITY_ODD);
`else
                  tx_d = LINE_IDLE;
`endif
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  tx_d      = shift_q[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               stop_cnt_d = 1'b0;
               tx_d       = LINE_IDLE;
            end
`endif
            STOP: begin
               if (stop_last) begin
                  done_d = 1'b1;
                  if (!buf_empty_q) begin
                     // Chain straight into the next start bit: no idle gap.
                     shift_d     = buf_q;
                     buf_empty_d = 1'b1;
                     tx_d        = START_BIT;
`ifdef UART_TX_PARITY_EN
                     parity_d    = ^buf_q;
`endif
                  end else begin
                     tx_d = LINE_IDLE;
                  end
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
                  tx_d       = LINE_IDLE;
               end
            end
            default: tx_d = LINE_IDLE;
         endcase
      end
   end

   assign busy_d = (state_d != IDLE);

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: the holding buffer and shifter are cleared on reset as well, so a byte
      // pending at reset can never leak into a later frame.
      if (rst) begin
         buf_q       <= '0;
         buf_empty_q <= 1'b1;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= 1'b0;
         tx_q        <= LINE_IDLE;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         buf_q       <= buf_d;
         buf_empty_q <= buf_empty_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         tx_q        <= tx_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign tx       = tx_q;
   assign tx_ready = buf_empty_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

endmodule : uart_tx
